// File: rtl/qam_pkg.sv
// Shared QAM transmitter types and constants: DAC frame width, DAC command, output-stage FSM states.
// Also holds the sample-to-frame packing used by the DAC serializer.
package qam_pkg;

   localparam int         FRAME_W              = 24;
   localparam logic [7:0] DAC_CMD_WRITE_UPDATE = 8'h30;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } dac_state_t;

   // Offset binary is two's complement with the sign bit flipped.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic [7:0]  cmd,
      input logic [15:0] sample,
      input logic        offset_bin
   );
      logic [15:0] code;
      code = sample;
      if (offset_bin) code[15] = ~sample[15];
      return {cmd, code};
   endfunction

endpackage

// File: rtl/sample_pend_buf.sv
// One-deep holding register for a sample that arrives while a DAC frame is in flight.
// Load when empty (or together with take) stores; load when full keeps the old sample and pulses overrun next cycle.
module sample_pend_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_take,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_overrun
);

   logic [W-1:0] r_data;
   logic         r_full;
   logic         r_ovr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data <= '0;
         r_full <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         r_ovr <= i_load && r_full && !i_take;
         // A take in the same cycle frees the slot, so the new sample lands without loss.
         if (i_load && (i_take || !r_full)) begin
            r_data <= i_data;
            r_full <= 1'b1;
         end else if (i_take) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_full    = r_full;
   assign o_overrun = r_ovr;

endmodule

// File: rtl/dac_spi_tx.sv
// Serializes each mixer sample as a 24-bit {CMD, code} SPI mode-0 frame to the DAC; cs falls one clk after the strobe.
// No backpressure: one sample is buffered during a frame, further strobes are dropped and flagged on overrun.
module dac_spi_tx
   import qam_pkg::*;
#(
   parameter int         CLK_DIV    = 2,
   parameter int         CS_HIGH    = 2,
   parameter logic [7:0] CMD        = DAC_CMD_WRITE_UPDATE,
   parameter bit         OFFSET_BIN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   output logic        cs,
   output logic        sclk,
   output logic        sdo,
   output logic        busy,
   output logic        overrun
);

   localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH - 1);

   dac_state_t         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [4:0]         r_bit;
   logic               r_hi;
   logic [FRAME_W-1:0] r_shift;
   logic               r_cs;
   logic               r_sclk;
   logic               r_sdo;
   logic               r_busy;

   dac_state_t         w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [4:0]         w_bit_nxt;
   logic               w_hi_nxt;
   logic [FRAME_W-1:0] w_shift_nxt;
   logic               w_cs_nxt;
   logic               w_sclk_nxt;
   logic               w_sdo_nxt;
   logic               w_take;
   logic               w_load;
   logic [15:0]        w_pend_dat;
   logic               w_pend_full;
   logic               w_pend_ovr;
   logic               w_div_end;
   logic               w_hold_end;

   assign w_div_end  = (r_cnt == DIV_LAST);
   assign w_hold_end = (r_cnt == HOLD_LAST);
   assign w_load     = sample_valid && (r_state != ST_IDLE);

   sample_pend_buf #(
      .W (16)
   ) u_pend (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_take    (w_take),
      .i_data    (sample_in),
      .o_data    (w_pend_dat),
      .o_full    (w_pend_full),
      .o_overrun (w_pend_ovr)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_hi_nxt    = r_hi;
      w_shift_nxt = r_shift;
      w_take      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (sample_valid) begin
               w_shift_nxt = build_frame(CMD, sample_in, OFFSET_BIN);
               w_state_nxt = ST_SETUP;
            end else if (w_pend_full) begin
               w_shift_nxt = build_frame(CMD, w_pend_dat, OFFSET_BIN);
               w_take      = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (w_div_end) begin
               w_cnt_nxt   = '0;
               w_hi_nxt    = 1'b1;
               w_bit_nxt   = 5'd23;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_div_end) begin
               w_cnt_nxt = '0;
               // Data moves on the falling sclk so it is settled a full half-period before the next rise.
               if (r_hi) begin
                  w_hi_nxt    = 1'b0;
                  w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
               end else if (r_bit == 5'd0) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_bit_nxt = r_bit - 5'd1;
                  w_hi_nxt  = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (w_hold_end) begin
               w_cnt_nxt = '0;
               if (w_pend_full) begin
                  w_shift_nxt = build_frame(CMD, w_pend_dat, OFFSET_BIN);
                  w_take      = 1'b1;
                  w_state_nxt = ST_SETUP;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_cs_nxt   = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD);
      w_sclk_nxt = (w_state_nxt == ST_SHIFT) && w_hi_nxt;
      w_sdo_nxt  = ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT)) ?
                   w_shift_nxt[FRAME_W-1] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_hi    <= 1'b0;
         r_shift <= '0;
         r_cs    <= 1'b1;
         r_sclk  <= 1'b0;
         r_sdo   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_hi    <= w_hi_nxt;
         r_shift <= w_shift_nxt;
         r_cs    <= w_cs_nxt;
         r_sclk  <= w_sclk_nxt;
         r_sdo   <= w_sdo_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign cs      = r_cs;
   assign sclk    = r_sclk;
   assign sdo     = r_sdo;
   assign busy    = r_busy;
   assign overrun = w_pend_ovr;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (defaults, CMD=A5/two's complement, CLK_DIV=CS_HIGH=1)
// share one clock; a negedge monitor decodes SPI frames and scenario tasks compare them with expected frames.
module tb_dac_spi_tx;

   logic        clk = 1'b0;
   logic        rst_v  [3];
   logic        sv     [3];
   logic [15:0] sin    [3];
   logic        cs_w   [3];
   logic        sclk_w [3];
   logic        sdo_w  [3];
   logic        busy_w [3];
   logic        ovr_w  [3];

   logic [7:0]  cmd_p [3] = '{8'h30, 8'hA5, 8'h30};
   bit          ob_p  [3] = '{1'b1, 1'b0, 1'b1};

   int n_vec = 0;
   int n_mis = 0;

   logic [23:0] exp_q  [3][$];
   logic [23:0] got_q  [3][$];
   int          len_q  [3][$];
   int          nbit_q [3][$];
   int          gap_q  [3][$];
   int          ovr_cnt [3];
   int          sclk_bad [3];

   bit          pcs    [3] = '{1'b1, 1'b1, 1'b1};
   bit          psclk  [3];
   int          lowlen [3];
   int          hilen  [3];
   int          nb     [3];
   logic [23:0] sh     [3];

   always #5 clk = ~clk;

   dac_spi_tx u_dut0 (
      .clk(clk), .rst(rst_v[0]), .sample_in(sin[0]), .sample_valid(sv[0]),
      .cs(cs_w[0]), .sclk(sclk_w[0]), .sdo(sdo_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
   );

   dac_spi_tx #(.CMD(8'hA5), .OFFSET_BIN(1'b0)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .sample_in(sin[1]), .sample_valid(sv[1]),
      .cs(cs_w[1]), .sclk(sclk_w[1]), .sdo(sdo_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
   );

   dac_spi_tx #(.CLK_DIV(1), .CS_HIGH(1)) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .sample_in(sin[2]), .sample_valid(sv[2]),
      .cs(cs_w[2]), .sclk(sclk_w[2]), .sdo(sdo_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2])
   );

   // SPI decoder: bits are taken on each sclk rise while cs is low, a frame is closed on cs rise.
   always @(negedge clk) begin
      bit c, s;
      for (int i = 0; i < 3; i++) begin
         c = (cs_w[i] !== 1'b0);
         s = (sclk_w[i] === 1'b1);
         if (pcs[i] && !c) begin
            gap_q[i].push_back(hilen[i]);
            lowlen[i] = 0;
            nb[i]     = 0;
            sh[i]     = '0;
         end
         if (!pcs[i] && c) begin
            got_q[i].push_back(sh[i]);
            len_q[i].push_back(lowlen[i]);
            nbit_q[i].push_back(nb[i]);
            hilen[i] = 0;
         end
         if (!c) begin
            lowlen[i]++;
            if (s && !psclk[i]) begin
               sh[i] = {sh[i][22:0], sdo_w[i] === 1'b1};
               nb[i]++;
            end
         end else begin
            hilen[i]++;
            if (s) sclk_bad[i]++;
         end
         if (ovr_w[i] === 1'b1) ovr_cnt[i]++;
         pcs[i]   = c;
         psclk[i] = s;
      end
   end

   function automatic logic [23:0] exp_frame(input logic [7:0] cmd, input logic [15:0] s, input bit ob);
      logic [15:0] code;
      code = ob ? {~s[15], s[14:0]} : s;
      return {cmd, code};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int i, input logic [15:0] v, input bit sent);
      if (sent) exp_q[i].push_back(exp_frame(cmd_p[i], v, ob_p[i]));
      sv[i]  = 1'b1;
      sin[i] = v;
      tick();
      sv[i]  = 1'b0;
   endtask

   task automatic clear_mon();
      for (int i = 0; i < 3; i++) begin
         exp_q[i].delete();
         got_q[i].delete();
         len_q[i].delete();
         nbit_q[i].delete();
         gap_q[i].delete();
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b0;
         sv[i]    = 1'b0;
         sin[i]   = '0;
      end
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (cs_w[i]   !== 1'b1) begin n_mis++; $display("FAIL reset_cs dut%0d: got %b want 1", i, cs_w[i]); end
         n_vec++; if (sclk_w[i] !== 1'b0) begin n_mis++; $display("FAIL reset_sclk dut%0d: got %b want 0", i, sclk_w[i]); end
         n_vec++; if (sdo_w[i]  !== 1'b0) begin n_mis++; $display("FAIL reset_sdo dut%0d: got %b want 0", i, sdo_w[i]); end
         n_vec++; if (busy_w[i] !== 1'b0) begin n_mis++; $display("FAIL reset_busy dut%0d: got %b want 0", i, busy_w[i]); end
         n_vec++; if (ovr_w[i]  !== 1'b0) begin n_mis++; $display("FAIL reset_overrun dut%0d: got %b want 0", i, ovr_w[i]); end
         rst_v[i] = 1'b1;
      end
      repeat (5) tick();
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (busy_w[i] !== 1'b0 || cs_w[i] !== 1'b1)
            begin n_mis++; $display("FAIL idle_after_reset dut%0d: busy %b cs %b want 0 1", i, busy_w[i], cs_w[i]); end
      end
      clear_mon();
   endtask

   task automatic test_single();
      int n;
      clear_mon();
      strobe(0, 16'h8000, 1'b1);
      n_vec++; if (cs_w[0] !== 1'b0)   begin n_mis++; $display("FAIL single_cs_fall: got %b want 0", cs_w[0]); end
      n_vec++; if (busy_w[0] !== 1'b1) begin n_mis++; $display("FAIL single_busy: got %b want 1", busy_w[0]); end
      n_vec++; if (sdo_w[0] !== 1'b0)  begin n_mis++; $display("FAIL single_sdo_msb: got %b want 0", sdo_w[0]); end
      n = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         n++;
         if (busy_w[0] === 1'b0) break;
      end
      n_vec++; if (n != 100) begin n_mis++; $display("FAIL single_busy_drop: got %0d want 100", n); end
      n_vec++;
      if (got_q[0].size() != 1) begin
         n_mis++; $display("FAIL single_frame_count: got %0d want 1", got_q[0].size());
      end else begin
         logic [23:0] g, e;
         g = got_q[0].pop_front();
         e = exp_q[0].pop_front();
         n_vec++; if (g !== e) begin n_mis++; $display("FAIL single_frame: got %h want %h", g, e); end
         n_vec++; if (len_q[0][0] != 98) begin n_mis++; $display("FAIL single_cs_low: got %0d want 98", len_q[0][0]); end
         n_vec++; if (nbit_q[0][0] != 24) begin n_mis++; $display("FAIL single_bits: got %0d want 24", nbit_q[0][0]); end
      end
   endtask

   task automatic test_cmd_twos();
      int bad0;
      clear_mon();
      bad0 = sclk_bad[1];
      n_vec++; if (sclk_w[1] !== 1'b0) begin n_mis++; $display("FAIL cmd_sclk_idle_before: got %b want 0", sclk_w[1]); end
      strobe(1, 16'h7FFF, 1'b1);
      n_vec++; if (sdo_w[1] !== 1'b1) begin n_mis++; $display("FAIL cmd_sdo_msb: got %b want 1", sdo_w[1]); end
      for (int k = 0; k < 300 && got_q[1].size() < 1; k++) tick();
      repeat (5) tick();
      n_vec++;
      if (got_q[1].size() != 1) begin
         n_mis++; $display("FAIL cmd_frame_count: got %0d want 1", got_q[1].size());
      end else begin
         logic [23:0] g, e;
         g = got_q[1].pop_front();
         e = exp_q[1].pop_front();
         n_vec++; if (g !== e) begin n_mis++; $display("FAIL cmd_frame: got %h want %h", g, e); end
         n_vec++; if (len_q[1][0] != 98) begin n_mis++; $display("FAIL cmd_cs_low: got %0d want 98", len_q[1][0]); end
      end
      n_vec++; if (sclk_w[1] !== 1'b0) begin n_mis++; $display("FAIL cmd_sclk_idle_after: got %b want 0", sclk_w[1]); end
      n_vec++; if (sclk_bad[1] != bad0) begin n_mis++; $display("FAIL cmd_sclk_cs_high: got %0d want 0", sclk_bad[1] - bad0); end
   endtask

   task automatic test_pending();
      int o0;
      clear_mon();
      o0 = ovr_cnt[0];
      strobe(0, 16'h0F0F, 1'b1);
      repeat (39) tick();
      strobe(0, 16'h1234, 1'b1);
      for (int k = 0; k < 400 && got_q[0].size() < 2; k++) tick();
      repeat (5) tick();
      n_vec++;
      if (got_q[0].size() != 2) begin
         n_mis++; $display("FAIL pend_frame_count: got %0d want 2", got_q[0].size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic [23:0] g, e;
            g = got_q[0].pop_front();
            e = exp_q[0].pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL pend_frame%0d: got %h want %h", k, g, e); end
         end
         n_vec++; if (gap_q[0].size() != 2 || gap_q[0][1] != 2)
            begin n_mis++; $display("FAIL pend_cs_gap: got %0d want 2", gap_q[0].size() > 1 ? gap_q[0][1] : -1); end
      end
      n_vec++; if (ovr_cnt[0] != o0) begin n_mis++; $display("FAIL pend_overrun: got %0d want 0", ovr_cnt[0] - o0); end
   endtask

   task automatic test_overrun();
      int o0;
      clear_mon();
      o0 = ovr_cnt[0];
      strobe(0, 16'h0001, 1'b1);
      repeat (9) tick();
      strobe(0, 16'h0002, 1'b1);
      n_vec++; if (ovr_w[0] !== 1'b0) begin n_mis++; $display("FAIL ovr_second: got %b want 0", ovr_w[0]); end
      repeat (9) tick();
      strobe(0, 16'h0003, 1'b0);
      n_vec++; if (ovr_w[0] !== 1'b1) begin n_mis++; $display("FAIL ovr_pulse: got %b want 1", ovr_w[0]); end
      tick();
      n_vec++; if (ovr_w[0] !== 1'b0) begin n_mis++; $display("FAIL ovr_one_cycle: got %b want 0", ovr_w[0]); end
      for (int k = 0; k < 400 && got_q[0].size() < 2; k++) tick();
      repeat (150) tick();
      n_vec++;
      if (got_q[0].size() != 2) begin
         n_mis++; $display("FAIL ovr_frame_count: got %0d want 2", got_q[0].size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic [23:0] g, e;
            g = got_q[0].pop_front();
            e = exp_q[0].pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL ovr_frame%0d: got %h want %h", k, g, e); end
         end
      end
      n_vec++; if (ovr_cnt[0] - o0 != 1) begin n_mis++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt[0] - o0); end
      n_vec++; if (busy_w[0] !== 1'b0) begin n_mis++; $display("FAIL ovr_idle_after: got %b want 0", busy_w[0]); end
   endtask

   task automatic test_reset_mid();
      int busy_hits;
      clear_mon();
      strobe(0, 16'h5555, 1'b1);
      repeat (9) tick();
      strobe(0, 16'h6666, 1'b1);
      repeat (45) tick();
      n_vec++; if (busy_w[0] !== 1'b1 || cs_w[0] !== 1'b0)
         begin n_mis++; $display("FAIL rmid_in_frame: busy %b cs %b want 1 0", busy_w[0], cs_w[0]); end
      rst_v[0] = 1'b0;
      tick();
      n_vec++; if (cs_w[0]   !== 1'b1) begin n_mis++; $display("FAIL rmid_cs: got %b want 1", cs_w[0]); end
      n_vec++; if (sclk_w[0] !== 1'b0) begin n_mis++; $display("FAIL rmid_sclk: got %b want 0", sclk_w[0]); end
      n_vec++; if (sdo_w[0]  !== 1'b0) begin n_mis++; $display("FAIL rmid_sdo: got %b want 0", sdo_w[0]); end
      n_vec++; if (busy_w[0] !== 1'b0) begin n_mis++; $display("FAIL rmid_busy: got %b want 0", busy_w[0]); end
      n_vec++; if (ovr_w[0]  !== 1'b0) begin n_mis++; $display("FAIL rmid_overrun: got %b want 0", ovr_w[0]); end
      rst_v[0] = 1'b1;
      busy_hits = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (busy_w[0] !== 1'b0) busy_hits++;
      end
      n_vec++; if (busy_hits != 0) begin n_mis++; $display("FAIL rmid_no_frame: busy cycles %0d want 0", busy_hits); end
      clear_mon();
      strobe(0, 16'h0000, 1'b1);
      for (int k = 0; k < 300 && got_q[0].size() < 1; k++) tick();
      n_vec++;
      if (got_q[0].size() != 1) begin
         n_mis++; $display("FAIL rmid_recover_count: got %0d want 1", got_q[0].size());
      end else begin
         logic [23:0] g, e;
         g = got_q[0].pop_front();
         e = exp_q[0].pop_front();
         n_vec++; if (g !== e) begin n_mis++; $display("FAIL rmid_recover_frame: got %h want %h", g, e); end
      end
      repeat (5) tick();
   endtask

   task automatic test_back_to_back();
      int n, o0;
      clear_mon();
      o0 = ovr_cnt[2];
      strobe(2, 16'hC3A5, 1'b1);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         n++;
         if (busy_w[2] === 1'b0) break;
      end
      n_vec++; if (n != 50) begin n_mis++; $display("FAIL b2b_period: got %0d want 50", n); end
      for (int k = 0; k < 4; k++) begin
         logic [15:0] v;
         v = 16'(16'h2345 * (k + 1));
         strobe(2, v, 1'b1);
         repeat (49) tick();
      end
      for (int k = 0; k < 400 && got_q[2].size() < 5; k++) tick();
      repeat (5) tick();
      n_vec++;
      if (got_q[2].size() != 5) begin
         n_mis++; $display("FAIL b2b_frame_count: got %0d want 5", got_q[2].size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            logic [23:0] g, e;
            int l;
            g = got_q[2].pop_front();
            e = exp_q[2].pop_front();
            l = len_q[2].pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL b2b_frame%0d: got %h want %h", k, g, e); end
            n_vec++; if (l != 49) begin n_mis++; $display("FAIL b2b_cs_low%0d: got %0d want 49", k, l); end
         end
      end
      n_vec++; if (ovr_cnt[2] != o0) begin n_mis++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt[2] - o0); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_cmd_twos();
      test_pending();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC output stage for the QAM transmitter: it accepts the 16-bit signed mixer output once per system-frequency enable strobe and drives it to an external SPI DAC as a 24-bit frame (8-bit command + 16-bit code). It sits directly downstream of the mixer and owns the board-level `cs`, `sclk` and `sdo` pins. A one-deep pending buffer absorbs a sample that arrives while a frame is in flight.

## Interface
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; must be ≥1.
- `CS_HIGH`, 2: minimum `clk` cycles `cs` stays high between frames; must be ≥1.
- `CMD`, 8'h30: command byte sent in frame bits [23:16].
- `OFFSET_BIN`, 1: when 1, invert sample MSB (two's complement → offset binary).

- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous, active-low.
- `sample_in` in 16: signed mixer sample.
- `sample_valid` in 1: one-cycle strobe (driven from `en_clk`); `sample_in` is captured on this cycle.
- `cs` out 1: DAC chip select, active-low.
- `sclk` out 1: serial clock, idle low.
- `sdo` out 1: serial data, MSB first.
- `busy` out 1: high while not in IDLE.
- `overrun` out 1: one-cycle pulse when a sample is dropped.

## Operation
- Frame = {`CMD`, code}, code = `sample_in` with bit 15 inverted if `OFFSET_BIN`.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE: `cs`=1, `sclk`=0, `sdo`=0. On `sample_valid` (or pending buffer full), load shift register and go to SETUP.
- SETUP: `cs`=0, `sclk`=0, `sdo`=frame[23]. Lasts `CLK_DIV` cycles, then SHIFT.
- SHIFT: per bit, `sclk`=1 for `CLK_DIV` cycles, then `sclk`=0 for `CLK_DIV` cycles. `sdo` advances to the next bit on the cycle `sclk` falls. A 5-bit bit counter counts 23→0. After bit 0's low phase, `cs`=1 and the FSM goes to HOLD.
- HOLD: `cs`=1 for `CS_HIGH` cycles. Then:
  - if the pending buffer is full, go to SETUP with the pending sample and clear the buffer;
  - else go to IDLE.
- Pending buffer: `sample_valid` while `busy` stores the sample into the buffer.
  - If the buffer is already full, the new sample is discarded. The old sample is kept and `overrun` pulses.
  - `sample_valid` on the same cycle HOLD drains the buffer: the drained sample is sent and the new one is stored. No overrun.
- `sample_valid` in IDLE loads directly; the buffer is unused.
- Reset (`rst`=0) at any time, including mid-frame, takes effect on the next `clk` edge:
  - state IDLE, `cs`=1, `sclk`=0, `sdo`=0, `busy`=0, `overrun`=0;
  - buffer empty; counters cleared.
- No partial-frame recovery after reset: the DAC discards a frame aborted by the `cs` rise.

## Timing
- Reset values: `cs`=1, `sclk`=0, `sdo`=0, `busy`=0, `overrun`=0.
- `sample_valid` at edge N in IDLE: `cs`=0, `busy`=1 and `sdo`=frame[23] are visible after edge N+1.
- `cs` low duration = `CLK_DIV`·(1+48) cycles (98 at defaults).
- Frame period = 98 + `CS_HIGH` = 100 cycles at defaults. `en_clk` spacing must be ≥ this for lossless output.
- First `sclk` rising edge occurs `CLK_DIV` cycles after `cs` falls.
- `sdo` is stable ≥`CLK_DIV` cycles around each `sclk` rising edge (the DAC samples on rising edge, SPI mode 0).
- All outputs are registered; no combinational path from inputs to pins.
- `overrun` is registered and asserts the cycle after the dropped strobe.

## Structure
- Shared package `qam_pkg`: `FRAME_W`=24, `DAC_CMD_WRITE_UPDATE`=8'h30, FSM state enum `dac_state_t`.
- One sub-module: `sample_pend_buf`, the one-deep pending register.
  - Ports: load, take, data in/out, full, overrun.
  - The FSM, the half-period counter and the shift register stay in `dac_spi_tx`.

## Test plan
- Reset, then single sample 16'h8000, `OFFSET_BIN`=1 → 24 bits captured on `sclk` rising edges = 24'h30_0000; `cs` low exactly 98 cycles; `busy` drops 100 cycles after `cs` fall.
- Sample 16'h7FFF, `OFFSET_BIN`=0, `CMD`=8'hA5 → frame 24'hA5_7FFF; `sdo` MSB first; `sclk` idle low before and after.
- Second `sample_valid` 40 cycles into a frame (value 16'h1234) → second frame starts immediately after HOLD (`cs` high exactly 2 cycles) carrying code 16'h9234; no `overrun`.
- Three strobes within one frame (16'h0001, 16'h0002, 16'h0003) → second frame carries 16'h0002 (offset: 16'h8002); `overrun` pulses once for 16'h0003.
- `rst` asserted at bit 10 of a frame, with the pending buffer full → next cycle `cs`=1, `sclk`=0, `sdo`=0, `busy`=0; no frame follows release until a new `sample_valid`.
- `CLK_DIV`=1, `CS_HIGH`=1 → `cs` low 49 cycles, period 50; back-to-back strobes every 50 cycles produce no `overrun`.
